// File: rtl/latch_pipe_pkg.sv
// Shared types and width helpers for the latch_pipe elastic buffer.
package latch_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/latch_pipe_mem.sv
// DEPTH x WIDTH register storage: one write port, asynchronous read port,
// asynchronous reset of every entry to INIT_VALUE.
module latch_pipe_mem #(
    parameter int                 WIDTH      = 8,
    parameter int                 DEPTH      = 2,
    parameter int                 PTR_W      = 1,
    parameter logic [WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Address decode by compare keeps DEPTH=1 and non-power-of-2 depths width-clean.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (waddr == PTR_W'(i)) mem_d[i] = wdata;
            end
        end
    end

    always_comb begin
        rdata = INIT_VALUE;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr == PTR_W'(i)) rdata = mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VALUE;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/latch_pipe.sv
// In-order valid/ready elastic buffer with synchronous set.
// Define LATCH_PIPE_BYPASS_EN for a transparent D->Q path while empty.
module latch_pipe
    import latch_pipe_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] SET_VALUE  = '1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                       C,
    input  logic                       R,
    input  logic [WIDTH-1:0]           D,
    input  logic                       D_VALID,
    output logic                       D_READY,
    input  logic                       S,
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VALID,
    input  logic                       Q_READY,
    output logic [cnt_w(DEPTH)-1:0]    COUNT
);

    localparam int               CNT_W    = cnt_w(DEPTH);
    localparam int               PTR_W    = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] SET_WPTR = (DEPTH == 1) ? '0 : PTR_W'(1);
    localparam state_e           ONE_ST   = (DEPTH == 1) ? FULL : PARTIAL;
    localparam state_e           POP_ST   = (DEPTH == 1) ? EMPTY : PARTIAL;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             d_ready_q, d_ready_d;

    logic             push, pop, bypass_take;
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_data;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    latch_pipe_mem #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W),
        .INIT_VALUE (INIT_VALUE)
    ) u_mem (
        .clk   (C),
        .rst_n (R),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        bypass_take = 1'b0;
`ifdef LATCH_PIPE_BYPASS_EN
        bypass_take = (state_q == EMPTY) & ~S & D_VALID & Q_READY;
`endif
        push      = D_VALID & d_ready_q & ~bypass_take;
        pop       = (count_q != '0) & Q_READY;

        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        we        = 1'b0;
        waddr     = wr_ptr_q;
        wdata     = D;

        if (S) begin
            // Set flushes everything and leaves SET_VALUE as the single entry at slot 0.
            we       = 1'b1;
            waddr    = '0;
            wdata    = SET_VALUE;
            rd_ptr_d = '0;
            wr_ptr_d = SET_WPTR;
            count_d  = CNT_W'(1);
            state_d  = ONE_ST;
        end else begin
            if (push) begin
                we       = 1'b1;
                wr_ptr_d = inc_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_d = inc_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            case (state_q)
                EMPTY:   if (push) state_d = ONE_ST;
                PARTIAL: begin
                    if (count_d == DEPTH_C)  state_d = FULL;
                    else if (count_d == '0)  state_d = EMPTY;
                end
                FULL:    if (pop && !push) state_d = POP_ST;
                default: state_d = EMPTY;
            endcase
        end

        d_ready_d = (count_d < DEPTH_C);
    end

    always_comb begin
        Q       = rd_data;
        Q_VALID = (count_q != '0);
`ifdef LATCH_PIPE_BYPASS_EN
        if (state_q == EMPTY && !S) begin
            Q       = D;
            Q_VALID = D_VALID;
        end
`endif
    end

    assign D_READY = d_ready_q;
    assign COUNT   = count_q;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q   <= EMPTY;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            d_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            d_ready_q <= d_ready_d;
        end
    end

endmodule
